// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter in front of a shared FIFO.
// A grant lasts until a word flagged last or MAX_BURST words; one IDLE cycle separates grants.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_last,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_last,
    output logic                  req1_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    state_t     state;
    state_t     state_next;
    logic [7:0] beat_cnt;
    logic [7:0] beat_cnt_next;
    logic       last_served;
    logic       last_served_next;
    logic [1:0] grant_next;

    // last_served resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            beat_cnt    <= 8'd0;
            last_served <= 1'b1;
            grant       <= 2'b00;
        end else begin
            state       <= state_next;
            beat_cnt    <= beat_cnt_next;
            last_served <= last_served_next;
            grant       <= grant_next;
        end
    end

    always_comb begin
        state_next       = state;
        beat_cnt_next    = beat_cnt;
        last_served_next = last_served;
        req0_ready       = 1'b0;
        req1_ready       = 1'b0;
        fifo_wr          = 1'b0;
        fifo_data        = '0;

        case (state)
            IDLE: begin
                // Counter is cleared here so every grant starts counting from zero.
                beat_cnt_next = 8'd0;
                if (req0_valid && req1_valid) begin
                    state_next = last_served ? GRANT0 : GRANT1;
                end else if (req0_valid) begin
                    state_next = GRANT0;
                end else if (req1_valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                req0_ready = req0_valid && !fifo_full;
                fifo_wr    = req0_ready;
                fifo_data  = req0_data;
                if (req0_ready) begin
                    beat_cnt_next = beat_cnt + 8'd1;
                    if (req0_last || (beat_cnt_next == BURST_LIMIT)) begin
                        state_next       = IDLE;
                        last_served_next = 1'b0;
                    end
                end
            end
            GRANT1: begin
                req1_ready = req1_valid && !fifo_full;
                fifo_wr    = req1_ready;
                fifo_data  = req1_data;
                if (req1_ready) begin
                    beat_cnt_next = beat_cnt + 8'd1;
                    if (req1_last || (beat_cnt_next == BURST_LIMIT)) begin
                        state_next       = IDLE;
                        last_served_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // grant is registered: it encodes the state being entered on this edge.
    always_comb begin
        grant_next = 2'b00;
        case (state_next)
            GRANT0:  grant_next = 2'b01;
            GRANT1:  grant_next = 2'b10;
            default: grant_next = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed sequences with literal expectations, then
// random traffic checked every cycle against a behavioural model and a per-requester scoreboard.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_last = 1'b0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_last = 1'b0;
    logic          req1_ready;
    logic          fifo_full = 1'b0;
    logic          fifo_wr;
    logic [DW-1:0] fifo_data;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_pass = 0;

    bit       sb_en = 1'b0;
    logic [6:0] sb_next0 = '0;
    logic [6:0] sb_next1 = '0;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    // Model state: owner -1 means idle; otherwise the requester holding the grant.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = 1;

    always @(negedge clk) begin : model_cmp
        logic [1:0]    eg;
        logic [1:0]    er;
        logic          ew;
        logic [DW-1:0] ed;
        logic [DW-1:0] sb_exp;
        bit            v;
        bit            lst;

        eg = 2'b00; er = 2'b00; ew = 1'b0; ed = '0;
        if (reset && m_owner >= 0) begin
            v   = (m_owner == 0) ? req0_valid : req1_valid;
            lst = (m_owner == 0) ? req0_last  : req1_last;
            eg  = (m_owner == 0) ? 2'b01 : 2'b10;
            ew  = v && !fifo_full;
            er  = ew ? eg : 2'b00;
            ed  = (m_owner == 0) ? req0_data : req1_data;
        end else begin
            lst = 1'b0;
        end

        n_checks++;
        if ({grant, req1_ready, req0_ready, fifo_wr, fifo_data} === {eg, er, ew, ed}) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL model_cycle t=%0t got grant=%b rdy=%b wr=%b data=%h expected grant=%b rdy=%b wr=%b data=%h",
                     $time, grant, {req1_ready, req0_ready}, fifo_wr, fifo_data, eg, er, ew, ed);
        end

        // Scoreboard: each requester's words must reach the FIFO once each, in order.
        if (sb_en && reset && fifo_wr && (grant == 2'b01 || grant == 2'b10)) begin
            sb_exp = (grant == 2'b01) ? {1'b0, sb_next0} : {1'b1, sb_next1};
            n_checks++;
            if (fifo_data === sb_exp) begin
                n_pass++;
            end else begin
                $display("[TB] FAIL scoreboard t=%0t got data=%h expected data=%h", $time, fifo_data, sb_exp);
            end
            if (grant == 2'b01) sb_next0 = sb_next0 + 7'd1;
            else                sb_next1 = sb_next1 + 7'd1;
        end

        if (!reset) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = 1;
        end else if (m_owner < 0) begin
            m_beats = 0;
            if (req0_valid && req1_valid) m_owner = (m_last == 1) ? 0 : 1;
            else if (req0_valid)          m_owner = 0;
            else if (req1_valid)          m_owner = 1;
        end else if (ew) begin
            m_beats = m_beats + 1;
            if (lst || m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    end

    task automatic apply_stimulus(input bit v0, input logic [7:0] d0, input bit l0,
                                  input bit v1, input logic [7:0] d1, input bit l1,
                                  input bit full);
        req0_valid = v0; req0_data = d0; req0_last = l0;
        req1_valid = v1; req1_data = d1; req1_last = l1;
        fifo_full  = full;
    endtask

    // Compares at the falling edge, then advances to just after the next rising edge.
    task automatic check_output(input string name, input logic [1:0] eg, input logic [1:0] er,
                                input logic ew, input logic [7:0] ed);
        @(negedge clk);
        n_checks++;
        if ({grant, req1_ready, req0_ready, fifo_wr, fifo_data} === {eg, er, ew, ed}) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s got grant=%b rdy=%b wr=%b data=%h expected grant=%b rdy=%b wr=%b data=%h",
                     name, grant, {req1_ready, req0_ready}, fifo_wr, fifo_data, eg, er, ew, ed);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [6:0] cnt0;
        logic [6:0] cnt1;
        bit a0;
        bit a1;

        apply_stimulus(1, 8'h10, 0, 1, 8'hA0, 1, 0);
        repeat (2) @(posedge clk);
        #2;
        check_output("reset_hold", 2'b00, 2'b00, 1'b0, 8'h00);
        reset = 1'b1;

        // Both valid after reset: requester 0 first, then requester 1 after one idle cycle.
        check_output("tie_idle", 2'b00, 2'b00, 1'b0, 8'h00);
        check_output("g0_word0", 2'b01, 2'b01, 1'b1, 8'h10);
        apply_stimulus(1, 8'h11, 1, 1, 8'hA0, 1, 0);
        check_output("g0_word1", 2'b01, 2'b01, 1'b1, 8'h11);
        apply_stimulus(0, 8'h00, 0, 1, 8'hA0, 1, 0);
        check_output("gap_idle", 2'b00, 2'b00, 1'b0, 8'h00);
        check_output("g1_word0", 2'b10, 2'b10, 1'b1, 8'hA0);
        apply_stimulus(0, 8'h00, 0, 0, 8'h00, 0, 0);
        check_output("idle_after", 2'b00, 2'b00, 1'b0, 8'h00);

        // Owner drops valid while the other waits: grant held, nothing written.
        apply_stimulus(1, 8'h20, 0, 1, 8'hB0, 0, 0);
        check_output("stall_arb", 2'b00, 2'b00, 1'b0, 8'h00);
        check_output("stall_w0", 2'b01, 2'b01, 1'b1, 8'h20);
        apply_stimulus(0, 8'h21, 0, 1, 8'hB0, 0, 0);
        check_output("stall_c1", 2'b01, 2'b00, 1'b0, 8'h21);
        check_output("stall_c2", 2'b01, 2'b00, 1'b0, 8'h21);
        apply_stimulus(1, 8'h21, 1, 1, 8'hB0, 0, 0);
        check_output("stall_w1", 2'b01, 2'b01, 1'b1, 8'h21);
        apply_stimulus(0, 8'h00, 0, 1, 8'hB0, 1, 0);
        check_output("stall_gap", 2'b00, 2'b00, 1'b0, 8'h00);
        check_output("stall_g1", 2'b10, 2'b10, 1'b1, 8'hB0);
        apply_stimulus(0, 8'h00, 0, 0, 8'h00, 0, 0);
        check_output("stall_end", 2'b00, 2'b00, 1'b0, 8'h00);

        // FIFO full for three cycles mid-packet.
        apply_stimulus(1, 8'h30, 0, 0, 8'h00, 0, 0);
        check_output("full_arb", 2'b00, 2'b00, 1'b0, 8'h00);
        apply_stimulus(1, 8'h30, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) check_output("full_hold", 2'b01, 2'b00, 1'b0, 8'h30);
        apply_stimulus(1, 8'h30, 0, 0, 8'h00, 0, 0);
        check_output("full_resume", 2'b01, 2'b01, 1'b1, 8'h30);
        apply_stimulus(1, 8'h31, 1, 0, 8'h00, 0, 0);
        check_output("full_last", 2'b01, 2'b01, 1'b1, 8'h31);
        apply_stimulus(0, 8'h00, 0, 0, 8'h00, 0, 0);
        check_output("full_end", 2'b00, 2'b00, 1'b0, 8'h00);

        // Six-word packet split by the burst limit into 4 + 2.
        apply_stimulus(0, 8'h00, 0, 1, 8'h40, 0, 0);
        check_output("burst_arb", 2'b00, 2'b00, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 8'h00, 0, 1, 8'(8'h40 + i), (i == 5), 0);
            if (i == 4) check_output("burst_gap", 2'b00, 2'b00, 1'b0, 8'h00);
            check_output("burst_word", 2'b10, 2'b10, 1'b1, 8'(8'h40 + i));
        end
        apply_stimulus(0, 8'h00, 0, 0, 8'h00, 0, 0);
        check_output("burst_end", 2'b00, 2'b00, 1'b0, 8'h00);

        // Reset mid-packet aborts at once; afterwards requester 0 wins the tie.
        apply_stimulus(0, 8'h00, 0, 1, 8'h50, 0, 0);
        check_output("rst_arb", 2'b00, 2'b00, 1'b0, 8'h00);
        check_output("rst_w0", 2'b10, 2'b10, 1'b1, 8'h50);
        reset = 1'b0;
        check_output("rst_abort", 2'b00, 2'b00, 1'b0, 8'h00);
        apply_stimulus(1, 8'h60, 1, 1, 8'h51, 1, 0);
        reset = 1'b1;
        check_output("rst_rel_idle", 2'b00, 2'b00, 1'b0, 8'h00);
        check_output("rst_rel_g0", 2'b01, 2'b01, 1'b1, 8'h60);
        apply_stimulus(0, 8'h00, 0, 0, 8'h00, 0, 0);
        check_output("rst_rel_end", 2'b00, 2'b00, 1'b0, 8'h00);

        // Random traffic: each requester offers a numbered word stream.
        cnt0 = '0;
        cnt1 = '0;
        sb_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus($urandom_range(0, 9) < 7, {1'b0, cnt0}, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 9) < 7, {1'b1, cnt1}, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 3) == 0);
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            @(posedge clk);
            #2;
            if (a0) cnt0 = cnt0 + 7'd1;
            if (a1) cnt1 = cnt1 + 7'd1;
        end
        sb_en = 1'b0;
        apply_stimulus(0, 8'h00, 0, 0, 8'h00, 0, 0);
        repeat (3) @(posedge clk);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
